cache_refill_ctrl: RTL and testbench
====================================

# cache_refill_ctrl

Miss-handling refill controller for the memory-stage direct-mapped data cache (8 sets, one 32-bit word per line, tag = address[31:5], set = address[4:2]). When the cache reports a read miss, this block stalls the pipeline and issues a single-word read to data memory using a req/ack handshake. It then writes the returned word, tag and set back into the cache through a one-cycle fill port. It is the memory-facing counterpart of the cache's hit path.

## Interface

**Parameters**
- `NUM_SET`, default 8: cache sets. Set index width is log2(NUM_SET) = 3. Tag width is 32-2-3 = 27.
- `TIMEOUT`, default 64: maximum cycles spent waiting for `MemAck`. A value of 0 disables the timeout.

**Ports**
- `clk`, in, 1: single clock. Everything is rising-edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `MissM`, in, 1: cache access missed this cycle (`!Hit` qualified by a memory access).
- `MemWriteM`, in, 1: the current access is a store.
- `ALUResultM`, in, 32: access address.
- `StallM`, out, 1: holds the pipeline.
- `MemReq`, out, 1: read request to data memory.
- `MemAddr`, out, 32: word-aligned request address.
- `MemAck`, in, 1: data memory has returned `MemRdata` this cycle.
- `MemRdata`, in, 32: read data from data memory.
- `FillEn`, out, 1: write strobe to the cache arrays (sets valid, tag and data).
- `FillSet`, out, 3: set index to fill.
- `FillTag`, out, 27: tag to fill.
- `FillData`, out, 32: word to fill.
- `ErrM`, out, 1: sticky timeout error.
- `RefillCount`, out, 16: count of completed refills, saturating.

## Operation

- The FSM has three states: IDLE, REQ and FILL. Encoding is free. Reset state is IDLE.
- **IDLE**
  - If `MissM & !MemWriteM`: latch `ALUResultM & ~32'h3` into `AddrQ`, clear the wait counter, go to REQ.
  - Store misses do not start a refill. Stores are written by the cache directly.
- **REQ**
  - `MemReq`=1 and `MemAddr`=`AddrQ`, both held stable until the state is left.
  - On `MemAck`: capture `MemRdata` into `DataQ`, go to FILL.
  - Otherwise the wait counter increments. When it reaches `TIMEOUT-1` with no ack (and `TIMEOUT` is not 0): set `ErrM`, go to IDLE without filling.
- **FILL**
  - `FillEn`=1 for exactly one cycle.
  - `FillSet`=`AddrQ[4:2]`, `FillTag`=`AddrQ[31:5]`, `FillData`=`DataQ`.
  - `RefillCount` increments and saturates at 16'hFFFF.
  - Go to IDLE.
- **Output rules**
  - `StallM` is combinational: (state != IDLE) | (state == IDLE & `MissM` & `!MemWriteM`).
  - `MemReq` and `FillEn` are decoded from registered state only.
- **Ignored inputs**
  - `MissM` is ignored outside IDLE.
  - `MemAck` is ignored outside REQ, so stray or late acks have no effect.
- **Sticky outputs**
  - `ErrM` stays set until `rst`. Later refills still proceed normally.
- **Widths**
  - The wait counter is clog2(`TIMEOUT`)+1 bits.
  - `FillTag` and `FillSet` are pure bit slices. No arithmetic is done on the address.

## Timing

- **Reset values.** Asserting `rst` immediately forces:
  - state = IDLE;
  - `MemReq`, `FillEn`, `ErrM` = 0;
  - `RefillCount`, `AddrQ`, `DataQ` and the counter = 0;
  - `MemAddr`, `FillSet`, `FillTag`, `FillData` = 0.
- **`StallM` during reset.** `StallM` follows its combinational equation and is 0 unless `MissM` is high.
- **Mid-operation reset.** A reset in REQ drops `MemReq` asynchronously. A reset in FILL suppresses the fill.
- **Cycle sequence** (miss sampled at cycle 0, `MemAck` arrives k cycles after entering REQ, k ≥ 0):

  | Cycle | State | Outputs |
  |---|---|---|
  | 0 | IDLE | `StallM`=1 |
  | 1 … 1+k | REQ | `MemReq`=1 |
  | 2+k | FILL | `FillEn`=1, `StallM`=1 |
  | 3+k | IDLE | `StallM`=0 |

  The cache hits on the replayed access in cycle 3+k.
- **Minimum miss penalty.** With `MemAck` in the first REQ cycle, the total is 3 stalled cycles.
- **Simultaneous events:**
  - `MemAck` in the same cycle the counter hits its limit: the ack wins, so there is a fill and no error.
  - `MissM` in the cycle FILL returns to IDLE: it is serviced in that IDLE cycle.
- **Timeout.** With `TIMEOUT`=64 and no ack, REQ lasts 64 cycles. `ErrM` rises on the clock edge that leaves REQ.

## Test plan

- **Reset check.** Hold `rst`=1 for 2 cycles, then release. Expect all outputs 0. `StallM`=0 while `MissM`=0.
- **Basic read refill.**
  - Stimulus: `MissM`=1, `MemWriteM`=0, `ALUResultM`=32'h0000_0047; `MemAck` in the 3rd REQ cycle with `MemRdata`=32'hCAFE_F00D.
  - Expect: `MemAddr`=32'h0000_0044; `FillSet`=3'd1; `FillTag`=27'h2; `FillData`=32'hCAFE_F00D.
  - Expect: `FillEn` high for exactly one cycle, `StallM` high for 5 cycles, `RefillCount`=1.
- **Store miss.** `MissM`=1, `MemWriteM`=1. Expect `StallM`=0, `MemReq` never asserted, state stays IDLE.
- **Timeout.**
  - Stimulus: `TIMEOUT`=4, read miss, `MemAck` held low.
  - Expect: `MemReq` high for 4 cycles, then `ErrM`=1 sticky, no `FillEn`, `RefillCount` unchanged.
  - Follow with a normal refill. Expect the fill to complete and `ErrM` to stay 1.
- **Mid-refill reset, then stray ack.**
  - Assert `rst` during REQ. Expect `MemReq` to drop in the same cycle.
  - Pulse `MemAck` while IDLE. Expect no `FillEn`.
- **Back-to-back misses.**
  - Stimulus: addresses 32'h100 then 32'h120 on consecutive misses, acks at k=0.
  - Expect two fills with `FillTag` 27'h8 and 27'h9, both at `FillSet`=0.
  - Expect `RefillCount`=2. The second `MemReq` starts 3 cycles after the first.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: read-miss refill controller for the direct-mapped D-cache.
// On a load miss it stalls the pipeline, fetches one word over a req/ack
// handshake and writes word, tag and set back through a one-cycle fill port.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   MissM, MemWriteM      cache miss this cycle / access is a store
//   ALUResultM            access address
//   StallM                pipeline hold (combinational)
//   MemReq, MemAddr       word read request to data memory
//   MemAck, MemRdata      read data valid / read data
//   FillEn, FillSet,
//   FillTag, FillData     one-cycle fill strobe and payload to cache arrays
//   ErrM                  sticky memory timeout flag
//   RefillCount           saturating count of completed refills
module cache_refill_ctrl #(
    parameter int NUM_SET = 8,
    parameter int TIMEOUT = 64,
    localparam int SW = $clog2(NUM_SET),
    localparam int TW = 30 - SW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          MissM,
    input  logic          MemWriteM,
    input  logic [31:0]   ALUResultM,
    output logic          StallM,
    output logic          MemReq,
    output logic [31:0]   MemAddr,
    input  logic          MemAck,
    input  logic [31:0]   MemRdata,
    output logic          FillEn,
    output logic [SW-1:0] FillSet,
    output logic [TW-1:0] FillTag,
    output logic [31:0]   FillData,
    output logic          ErrM,
    output logic [15:0]   RefillCount
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] FILL = 2'd2;

    localparam int CW = $clog2(TIMEOUT) + 1;
    // Last wait-counter value before giving up; unused when TIMEOUT is 0.
    localparam logic [CW-1:0] LIM = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [31:0]   addr_q;
    logic [31:0]   data_q;
    logic [CW-1:0] wait_cnt;
    logic          start;

    assign start = MissM & ~MemWriteM;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            wait_cnt    <= '0;
            ErrM        <= 1'b0;
            RefillCount <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        addr_q   <= ALUResultM & ~32'h3;
                        wait_cnt <= '0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    // An ack on the limit cycle still wins over the timeout.
                    if (MemAck) begin
                        data_q <= MemRdata;
                        state  <= FILL;
                    end else if (TIMEOUT != 0 && wait_cnt == LIM) begin
                        ErrM  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                FILL: begin
                    if (RefillCount != 16'hFFFF)
                        RefillCount <= RefillCount + 16'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign StallM  = (state != IDLE) | start;
    assign MemReq  = (state == REQ);
    assign FillEn  = (state == FILL);
    // Payload buses are zero whenever their strobe is low.
    assign MemAddr  = MemReq ? addr_q : '0;
    assign FillSet  = FillEn ? addr_q[2+SW-1:2] : '0;
    assign FillTag  = FillEn ? addr_q[31:2+SW] : '0;
    assign FillData = FillEn ? data_q : '0;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed bench for cache_refill_ctrl (TIMEOUT=4).
// Linear stimulus with hand-computed expectations checked by assertions.
module tb_cache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MissM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic        StallM;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck;
    logic [31:0] MemRdata;
    logic        FillEn;
    logic [2:0]  FillSet;
    logic [26:0] FillTag;
    logic [31:0] FillData;
    logic        ErrM;
    logic [15:0] RefillCount;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int stall_n;
    int req1;

    cache_refill_ctrl #(.NUM_SET(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .MissM(MissM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
        .StallM(StallM), .MemReq(MemReq), .MemAddr(MemAddr),
        .MemAck(MemAck), .MemRdata(MemRdata),
        .FillEn(FillEn), .FillSet(FillSet), .FillTag(FillTag),
        .FillData(FillData), .ErrM(ErrM), .RefillCount(RefillCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; MissM = 1'b0; MemWriteM = 1'b0; ALUResultM = '0;
        MemAck = 1'b0; MemRdata = '0;
        #1;
        // Reset
        tick(); tick();
        check("rst_stall", 32'(StallM), 0);
        check("rst_req", 32'(MemReq), 0);
        rst = 1'b0;
        tick();
        check("idle_stall", 32'(StallM), 0);
        check("idle_req", 32'(MemReq), 0);
        check("idle_fill", 32'(FillEn), 0);
        check("idle_err", 32'(ErrM), 0);
        check("idle_cnt", 32'(RefillCount), 0);
        check("idle_addr", MemAddr, 0);
        check("idle_fdata", FillData, 0);

        // Basic refill, ack in 3rd REQ cycle
        stall_n = 0;
        MissM = 1'b1; ALUResultM = 32'h0000_0047;
        #1;
        check("b_stall0", 32'(StallM), 1);
        check("b_req0", 32'(MemReq), 0);
        stall_n += int'(StallM);
        tick();
        MissM = 1'b0; ALUResultM = '0;
        check("b_req1", 32'(MemReq), 1);
        check("b_addr", MemAddr, 32'h44);
        stall_n += int'(StallM);
        tick();
        check("b_req2", 32'(MemReq), 1);
        stall_n += int'(StallM);
        tick();
        check("b_req3", 32'(MemReq), 1);
        check("b_fill_early", 32'(FillEn), 0);
        stall_n += int'(StallM);
        MemAck = 1'b1; MemRdata = 32'hCAFE_F00D;
        tick();
        MemAck = 1'b0; MemRdata = '0;
        check("b_fillen", 32'(FillEn), 1);
        check("b_fset", 32'(FillSet), 1);
        check("b_ftag", 32'(FillTag), 2);
        check("b_fdata", FillData, 32'hCAFE_F00D);
        check("b_req_off", 32'(MemReq), 0);
        stall_n += int'(StallM);
        tick();
        check("b_fill_once", 32'(FillEn), 0);
        check("b_stall_end", 32'(StallM), 0);
        check("b_stall_n", 32'(stall_n), 5);
        check("b_count", 32'(RefillCount), 1);

        // Store miss
        MissM = 1'b1; MemWriteM = 1'b1; ALUResultM = 32'h80;
        #1;
        check("s_stall", 32'(StallM), 0);
        tick();
        check("s_req", 32'(MemReq), 0);
        check("s_stall1", 32'(StallM), 0);
        tick();
        check("s_req2", 32'(MemReq), 0);
        MissM = 1'b0; MemWriteM = 1'b0;

        // Ack on the timeout-limit cycle wins
        MissM = 1'b1; ALUResultM = 32'h84;
        tick();
        MissM = 1'b0;
        tick(); tick(); tick();
        check("l_req4", 32'(MemReq), 1);
        MemAck = 1'b1; MemRdata = 32'h1234_5678;
        tick();
        MemAck = 1'b0;
        check("l_fillen", 32'(FillEn), 1);
        check("l_fdata", FillData, 32'h1234_5678);
        check("l_err", 32'(ErrM), 0);
        tick();
        check("l_count", 32'(RefillCount), 2);

        // Timeout with no ack
        MissM = 1'b1; ALUResultM = 32'h10;
        tick();
        MissM = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t_req", 32'(MemReq), 1);
            check("t_err_pre", 32'(ErrM), 0);
            tick();
        end
        check("t_req_off", 32'(MemReq), 0);
        check("t_err", 32'(ErrM), 1);
        check("t_nofill", 32'(FillEn), 0);
        check("t_count", 32'(RefillCount), 2);
        tick();
        check("t_nofill2", 32'(FillEn), 0);
        check("t_sticky", 32'(ErrM), 1);

        // Normal refill after timeout
        MissM = 1'b1; ALUResultM = 32'h64;
        tick();
        MissM = 1'b0;
        MemAck = 1'b1; MemRdata = 32'hA5A5_0001;
        tick();
        MemAck = 1'b0;
        check("a_fillen", 32'(FillEn), 1);
        check("a_ftag", 32'(FillTag), 3);
        check("a_fset", 32'(FillSet), 1);
        tick();
        check("a_count", 32'(RefillCount), 3);
        check("a_err", 32'(ErrM), 1);

        // Reset mid-REQ, then stray ack
        MissM = 1'b1; ALUResultM = 32'h8;
        tick();
        MissM = 1'b0;
        check("r_req", 32'(MemReq), 1);
        #2;
        rst = 1'b1;
        #1;
        check("r_req_drop", 32'(MemReq), 0);
        check("r_err_clr", 32'(ErrM), 0);
        check("r_cnt_clr", 32'(RefillCount), 0);
        tick();
        rst = 1'b0;
        MemAck = 1'b1; MemRdata = 32'hDEAD_BEEF;
        tick();
        MemAck = 1'b0;
        check("r_nofill", 32'(FillEn), 0);
        check("r_noreq", 32'(MemReq), 0);
        tick();
        check("r_nofill2", 32'(FillEn), 0);
        check("r_cnt", 32'(RefillCount), 0);

        // Back-to-back misses
        MissM = 1'b1; ALUResultM = 32'h100;
        tick();
        req1 = cyc;
        MissM = 1'b0;
        check("bb_req1", 32'(MemReq), 1);
        MemAck = 1'b1; MemRdata = 32'h0000_1111;
        tick();
        MemAck = 1'b0;
        check("bb_fill1", 32'(FillEn), 1);
        check("bb_tag1", 32'(FillTag), 27'h8);
        check("bb_set1", 32'(FillSet), 0);
        MissM = 1'b1; ALUResultM = 32'h120;
        tick();
        check("bb_stall_idle", 32'(StallM), 1);
        check("bb_cnt1", 32'(RefillCount), 1);
        tick();
        MissM = 1'b0;
        check("bb_req2", 32'(MemReq), 1);
        check("bb_gap", 32'(cyc - req1), 3);
        check("bb_addr2", MemAddr, 32'h120);
        MemAck = 1'b1; MemRdata = 32'h0000_2222;
        tick();
        MemAck = 1'b0;
        check("bb_fill2", 32'(FillEn), 1);
        check("bb_tag2", 32'(FillTag), 27'h9);
        check("bb_set2", 32'(FillSet), 0);
        tick();
        check("bb_cnt2", 32'(RefillCount), 2);
        check("bb_stall_end", 32'(StallM), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
